// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key sequencer.
package ps2_pkg;

  // Prefix decode states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PFX_EXT  = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR_CODE = 8'h00;

  // Decoded key event; 'rel' marks a break (release) code
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

  function automatic ps2_event_t ps2_make_event(input logic       ext,
                                                input logic       rel,
                                                input logic [7:0] code);
    ps2_event_t ev;
    ev.ext  = ext;
    ev.rel  = rel;
    ev.code = code;
    return ev;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Event FIFO: power-of-two depth, first-word-fall-through head, drop-on-full.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  ps2_event_t               i_data,
  input  logic                     i_pop,
  output ps2_event_t               o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  ps2_event_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_rd;
  logic            w_wr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  // A pop frees the slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign w_rd    = i_pop && !w_empty;
  assign w_wr    = i_push && (!w_full || w_rd);

  assign o_drop  = i_push && w_full && !w_rd;
  assign o_valid = !w_empty;
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap modulo DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into key events and queues them.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PREFIX_TIMEOUT = 5_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    key_code,
  input  logic                          data_ready,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_release,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          seq_err,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int unsigned TW       = 32;
  localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT) - TW'(1);

  ps2_state_t      r_state;
  logic [TW-1:0]   r_tmo;
  logic            r_seq_err;
  logic            r_overflow;

  logic            w_is_err;
  logic            w_is_ext;
  logic            w_is_brk;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  logic            w_ev_ext;
  logic            w_ev_rel;
  ps2_event_t      w_ev_in;
  ps2_event_t      w_head;

  assign w_is_err = (key_code == PS2_ERR_CODE);
  assign w_is_ext = (key_code == PS2_PFX_EXT);
  assign w_is_brk = (key_code == PS2_PFX_BRK);

  // Prefix flags come from the state the completing byte arrives in
  assign w_ev_ext = (r_state == GOT_E0) || (r_state == GOT_E0F0);
  assign w_ev_rel = (r_state == GOT_F0) || (r_state == GOT_E0F0);
  assign w_ev_in  = ps2_make_event(w_ev_ext, w_ev_rel, key_code);

  // Any non-prefix, non-error byte completes an event; strobes during reset are ignored
  assign w_push = data_ready && !rst && !w_is_err && !w_is_ext && !w_is_brk;
  assign w_pop  = ev_ready && !rst;

  // Prefix FSM with timeout; every accepted byte restarts the timeout window
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tmo     <= '0;
      r_seq_err <= 1'b0;
    end else begin
      r_seq_err <= 1'b0;
      if (data_ready) begin
        r_tmo <= '0;
        if (w_is_err) begin
          r_state   <= IDLE;
          r_seq_err <= 1'b1;
        end else if (w_is_ext) begin
          // A fresh E0 restarts the sequence; a stray one mid-sequence is flagged
          if (r_state != IDLE) begin
            r_seq_err <= 1'b1;
          end
          r_state <= GOT_E0;
        end else if (w_is_brk) begin
          case (r_state)
            IDLE:    r_state <= GOT_F0;
            GOT_E0:  r_state <= GOT_E0F0;
            default: begin
              r_state   <= r_state;
              r_seq_err <= 1'b1;
            end
          endcase
        end else begin
          r_state <= IDLE;
        end
      end else if (r_state != IDLE) begin
        // Abandon a prefix whose follow-up byte never arrived
        if (r_tmo >= TMO_LAST) begin
          r_state   <= IDLE;
          r_tmo     <= '0;
          r_seq_err <= 1'b1;
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
      end else begin
        r_tmo <= '0;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_ev_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (ev_valid),
    .o_count (ev_count),
    .o_drop  (w_drop)
  );

  assign ev_code    = w_head.code;
  assign ev_ext     = w_head.ext;
  assign ev_release = w_head.rel;
  assign seq_err    = r_seq_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer with hand-computed expectations.
module tb_ps2_key_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;

  logic       clk;
  logic       rst;
  logic [7:0] key_code;
  logic       data_ready;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_release;
  logic [2:0] ev_count;
  logic       seq_err;
  logic       overflow;
  logic       ovf_clr;

  int n_vec;
  int n_err;
  int seq_cnt;
  int seq_base;

  ps2_key_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .PREFIX_TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_code   (key_code),
    .data_ready (data_ready),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_release (ev_release),
    .ev_count   (ev_count),
    .seq_err    (seq_err),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count seq_err pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && seq_err) seq_cnt <= seq_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] code);
    key_code   = code;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    key_code   = 8'h00;
  endtask

  // Check head event then pop it
  task automatic pop_chk(input string tag, input logic ext, input logic rel, input logic [7:0] code);
    chk({tag, "_valid"}, 32'(ev_valid), 32'd1);
    chk({tag, "_ev"}, {21'd0, ev_ext, ev_release, 1'b0, ev_code}, {21'd0, ext, rel, 1'b0, code});
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; seq_cnt = 0;
    rst = 1'b1; key_code = 8'h00; data_ready = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick(); tick();
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_count", 32'(ev_count), 32'd0);
    chk("rst_seqerr", 32'(seq_err), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();

    // Plain make code, one-cycle latency
    strobe(8'h1C);
    chk("make_count", 32'(ev_count), 32'd1);
    pop_chk("make", 1'b0, 1'b0, 8'h1C);
    chk("make_empty", 32'(ev_valid), 32'd0);
    chk("make_noerr", 32'(seq_cnt), 32'd0);

    // Extended break and plain break
    strobe(8'hE0);
    strobe(8'hF0);
    chk("pfx_noev", 32'(ev_valid), 32'd0);
    strobe(8'h75);
    chk("e0f0_count", 32'(ev_count), 32'd1);
    pop_chk("e0f0", 1'b1, 1'b1, 8'h75);
    strobe(8'hF0);
    strobe(8'h1C);
    pop_chk("f0", 1'b0, 1'b1, 8'h1C);
    strobe(8'hE0);
    strobe(8'h6B);
    pop_chk("e0", 1'b1, 1'b0, 8'h6B);
    chk("pfx_noerr", 32'(seq_cnt), 32'd0);

    // Prefix timeout
    seq_base = seq_cnt;
    strobe(8'hE0);
    for (int i = 0; i < int'(TMO) + 20; i++) tick();
    strobe(8'h1C);
    chk("tmo_seqerr", 32'(seq_cnt - seq_base), 32'd1);
    pop_chk("tmo", 1'b0, 1'b0, 8'h1C);

    // Repeated prefixes
    seq_base = seq_cnt;
    strobe(8'hE0);
    strobe(8'hE0);
    chk("e0e0_pulse", 32'(seq_err), 32'd1);
    strobe(8'h1C);
    pop_chk("e0e0", 1'b1, 1'b0, 8'h1C);
    strobe(8'hF0);
    strobe(8'hF0);
    strobe(8'h1C);
    pop_chk("f0f0", 1'b0, 1'b1, 8'h1C);
    chk("rep_seqerr", 32'(seq_cnt - seq_base), 32'd2);

    // ev_ready while empty has no effect
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    chk("empty_pop", 32'(ev_count), 32'd0);

    // Overflow with FIFO_DEPTH+1 pushes
    strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44); strobe(8'h55);
    chk("ovf_count", 32'(ev_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    pop_chk("ovf0", 1'b0, 1'b0, 8'h11);
    pop_chk("ovf1", 1'b0, 1'b0, 8'h22);
    pop_chk("ovf2", 1'b0, 1'b0, 8'h33);
    pop_chk("ovf3", 1'b0, 1'b0, 8'h44);
    chk("ovf_empty", 32'(ev_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with simultaneous push and pop
    strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44);
    chk("full_count", 32'(ev_count), 32'd4);
    ev_ready = 1'b1;
    strobe(8'h66);
    ev_ready = 1'b0;
    chk("pp_count", 32'(ev_count), 32'd4);
    chk("pp_ovf", 32'(overflow), 32'd0);
    pop_chk("pp0", 1'b0, 1'b0, 8'h22);
    pop_chk("pp1", 1'b0, 1'b0, 8'h33);
    pop_chk("pp2", 1'b0, 1'b0, 8'h44);
    pop_chk("pp3", 1'b0, 1'b0, 8'h66);

    // Drop coinciding with clear leaves overflow set
    strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44);
    ovf_clr = 1'b1;
    strobe(8'h55);
    ovf_clr = 1'b0;
    chk("ovf_race", 32'(overflow), 32'd1);
    pop_chk("race0", 1'b0, 1'b0, 8'h11);
    pop_chk("race1", 1'b0, 1'b0, 8'h22);
    pop_chk("race2", 1'b0, 1'b0, 8'h33);
    pop_chk("race3", 1'b0, 1'b0, 8'h44);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Reset mid-sequence discards the prefix
    strobe(8'hF0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    strobe(8'h1C);
    pop_chk("midrst", 1'b0, 1'b0, 8'h1C);

    // Strobe coincident with reset is ignored
    rst = 1'b1;
    strobe(8'h2A);
    rst = 1'b0;
    chk("rst_strobe", 32'(ev_count), 32'd0);

    // Error byte
    seq_base = seq_cnt;
    strobe(8'hE0);
    strobe(8'h00);
    chk("err_pulse", 32'(seq_err), 32'd1);
    chk("err_noev", 32'(ev_valid), 32'd0);
    tick();
    chk("err_once", 32'(seq_cnt - seq_base), 32'd1);
    strobe(8'h1C);
    pop_chk("err_idle", 1'b0, 1'b0, 8'h1C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
